secjmp_fetch_q: RTL and testbench

SECJMP_FETCH_Q -- requirements
Module: secjmp_fetch_q

---
 rtl/secjmp_pkg.sv | 26 ++
 rtl/secjmp_fetch_mem.sv | 28 ++
 rtl/secjmp_fetch_q.sv | 93 +++++++++
 tb/tb_secjmp_fetch_q.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/secjmp_pkg.sv
// Shared secjmp definitions: fetch word layout and the jump opcodes that the
// downstream secjmp filter squashes.
package secjmp_pkg;

  localparam int WORD_W = 64;
  localparam int INSN_W = 32;

  localparam logic [5:0]        OP_J   = 6'h02;
  localparam logic [5:0]        OP_JAL = 6'h03;
  localparam logic [INSN_W-1:0] NOP    = 32'h00000000;

  // Fetch word as carried through the queue: PC in the upper half.
  typedef struct packed {
    logic [WORD_W-INSN_W-1:0] pc;
    logic [INSN_W-1:0]        insn;
  } fetch_word_t;

  function automatic logic [5:0] insn_opcode(input logic [INSN_W-1:0] insn);
    return insn[INSN_W-1 -: 6];
  endfunction

  function automatic logic is_direct_jump(input logic [INSN_W-1:0] insn);
    return (insn_opcode(insn) == OP_J) || (insn_opcode(insn) == OP_JAL);
  endfunction

endpackage

// File: rtl/secjmp_fetch_mem.sv
// Fetch queue storage: DEPTH x W words, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module secjmp_fetch_mem
  import secjmp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/secjmp_fetch_q.sv
// Instruction fetch queue ahead of the secjmp filter; words pass unmodified.
// Optional 0-cycle empty-queue bypass enabled by defining SECJMP_FETCH_BYPASS_EN.
module secjmp_fetch_q
  import secjmp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WORD_W-1:0] mem_rd_data;
  logic              full, empty;
  logic              push, pop, store, bypass_take;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    // in_ready depends only on state, flush and rst, never on out_ready.
    in_ready    = !full && !flush && !rst;
    out_valid   = !empty && !flush;
    out_data    = mem_rd_data;
    bypass_take = 1'b0;
`ifdef SECJMP_FETCH_BYPASS_EN
    if (empty && !flush && !rst) begin
      out_valid = in_valid;
      out_data  = in_data;
    end
`endif
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
`ifdef SECJMP_FETCH_BYPASS_EN
    // A word consumed straight from the input never enters storage.
    bypass_take = empty && push && pop;
`endif
    store = push && !bypass_take;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!bypass_take) begin
      if (store) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  secjmp_fetch_mem #(
    .DEPTH (DEPTH),
    .W     (WORD_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (store),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_secjmp_fetch_q.sv
// Directed self-checking bench for secjmp_fetch_q (DEPTH = 4).
module tb_secjmp_fetch_q;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        flush;
  logic [2:0]  count;

  int total;
  int bad;

  secjmp_fetch_q #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int t);
    logic [31:0] pc;
    logic [31:0] insn;
    pc   = 32'h0000_4000 + 32'(t) * 32'd4;
    insn = 32'h0C00_0000 ^ 32'(t);
    return {pc, insn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    $display("txn reset: count=%0d in_ready=%b", count, in_ready);
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_data  = {32'h0000_1000, 32'h20210001};
`ifdef SECJMP_FETCH_BYPASS_EN
    out_ready = 1'b0;
`else
    out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_latency got=%b exp=0", out_valid); end
`endif
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data[31:0] !== 32'h20210001) begin bad++; $display("FAIL single_data got=%h exp=20210001", out_data[31:0]); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", count); end
    step();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", out_valid); end
    $display("txn single: insn=20210001 count=%0d", count);
  endtask

  task automatic test_fill();
    logic [31:0] fw [5];
    logic [63:0] w  [5];
    fw[0] = 32'h08000000; fw[1] = 32'h0800FACE; fw[2] = 32'h0C000000;
    fw[3] = 32'h0C00FACE; fw[4] = 32'h20210001;
    for (int i = 0; i < 5; i++) w[i] = {32'h0000_2000 + 32'(i) * 32'd4, fw[i]};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      #1;
      total++; if (in_ready !== (i < 4)) begin bad++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, (i < 4)); end
      if (i < 4) step();
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_pop_no_push got=%b exp=0", in_ready); end
    total++; if (out_data !== w[0]) begin bad++; $display("FAIL fill_order[0] got=%h exp=%h", out_data, w[0]); end
    step();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fill_count_after_pop got=%0d exp=3", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_5th_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== w[1]) begin bad++; $display("FAIL fill_order[1] got=%h exp=%h", out_data, w[1]); end
    step();
    in_valid = 1'b0;
    for (int j = 2; j < 5; j++) begin
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fill_drain_valid[%0d] got=%b exp=1", j, out_valid); end
      total++; if (out_data !== w[j]) begin bad++; $display("FAIL fill_order[%0d] got=%h exp=%h", j, out_data, w[j]); end
      $display("txn drain: word=%0d data=%h", j, out_data);
      step();
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL fill_final_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_final_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q [$];
    logic        exp_ready;
    int          nxt;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = mk(100 + i);
      q.push_back(mk(100 + i));
      step();
    end
    nxt = 104;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid  = 1'b1;
      in_data   = mk(nxt);
      exp_ready = (q.size() < 4);
      #1;
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b exp=%b", c, in_ready, exp_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid[%0d] got=%b exp=1", c, out_valid); end
      total++; if (out_data !== q[0]) begin bad++; $display("FAIL b2b_order[%0d] got=%h exp=%h", c, out_data, q[0]); end
      total++; if (count !== 3'(q.size())) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", c, count, q.size()); end
      $display("txn b2b: cycle=%0d out=%h in_ready=%b", c, out_data, in_ready);
      void'(q.pop_front());
      if (exp_ready) begin
        q.push_back(mk(nxt));
        nxt++;
      end
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      #1;
      total++; if (out_data !== q[0]) begin bad++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", k, out_data, q[0]); end
      void'(q.pop_front());
      step();
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_final_count got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = mk(200 + i);
      step();
    end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = mk(299);
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_after_valid got=%b exp=0", out_valid); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(210);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (out_data !== mk(210)) begin bad++; $display("FAIL flush_next_word got=%h exp=%h", out_data, mk(210)); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL flush_next_count got=%0d exp=1", count); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_residue got=%b exp=0", out_valid); end
    $display("txn flush: count=%0d", count);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = mk(300 + i);
      step();
    end
    in_data = mk(302);
    #2;
    rst = 1'b1;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL arst_in_ready got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_release_ready got=%b exp=1", in_ready); end
    in_valid = 1'b1;
    in_data  = mk(310);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (out_data !== mk(310)) begin bad++; $display("FAIL arst_next_word got=%h exp=%h", out_data, mk(310)); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL arst_next_count got=%0d exp=1", count); end
    step();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL arst_final_count got=%0d exp=0", count); end
    $display("txn async_reset: count=%0d", count);
  endtask

`ifdef SECJMP_FETCH_BYPASS_EN
  task automatic test_bypass();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {32'h0000_3000, 32'h0C00FACE};
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%b exp=1", out_valid); end
    total++; if (out_data[31:0] !== 32'h0C00FACE) begin bad++; $display("FAIL bypass_data got=%h exp=0c00face", out_data[31:0]); end
    step();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL bypass_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bypass_not_stored got=%b exp=0", out_valid); end
    $display("txn bypass: count=%0d", count);
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef SECJMP_FETCH_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
